// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch stage: opcodes, branch encodings, IR field layout
// and the fetch FSM state type.
package fetch_pc_unit_pkg;

   typedef enum logic [3:0] {
      OP_ALU   = 4'h0,
      OP_ALUI  = 4'h1,
      OP_LOAD  = 4'h2,
      OP_STORE = 4'h3,
      OP_BR    = 4'h4,
      OP_JMP   = 4'h5,
      OP_MOV   = 4'h6,
      OP_CMOV  = 4'h7,
      OP_NOP   = 4'hE,
      OP_HALT  = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      BR_NONE   = 3'b000,
      BR_ALWAYS = 3'b001,
      BR_MI     = 3'b010,
      BR_PL     = 3'b011,
      BR_Z      = 3'b100
   } branch_e;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_READY
   } fetch_state_e;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 28;
   localparam int RD_MSB  = 27;
   localparam int RD_LSB  = 24;
   localparam int RS1_MSB = 23;
   localparam int RS1_LSB = 20;
   localparam int RS2_MSB = 19;
   localparam int RS2_LSB = 16;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [31:0] NOP_WORD = {OP_NOP, 28'h000_0000};

endpackage

// File: rtl/fetch_pc_unit_branch_resolve.sv
// Combinational branch resolution: evaluates the BRANCH condition against the flags
// and selects the next PC (relative target or sequential), wrapping mod 2^PC_W.
module branch_resolve
   import fetch_pc_unit_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [2:0]      branch,
   input  logic            flag_neg,
   input  logic            flag_zero,
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     imm,
   output logic            taken,
   output logic [PC_W-1:0] next_pc
);

   // Wide enough for any PC_W; the low PC_W bits give both sign extension and truncation.
   logic [PC_W+15:0] imm_ext;

   assign imm_ext = {{PC_W{imm[15]}}, imm};

   // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      taken = 1'b0;
      case (branch)
         BR_ALWAYS: taken = 1'b1;
         BR_MI:     taken = flag_neg;
         BR_PL:     taken = !flag_neg && !flag_zero;
         BR_Z:      taken = flag_zero;
         default:   taken = 1'b0;
      endcase
   end

   assign next_pc = taken ? pc + imm_ext[PC_W-1:0] : pc + PC_W'(1);

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage: REQ/WAIT/READY fetch from a 1-cycle
// synchronous ROM into the IR, with loadPC committing the resolved next PC.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int                PC_W     = 16,
   parameter int                INSTR_W  = 32,
   parameter logic [PC_W-1:0]   RESET_PC = '0,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_WORD)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               loadPC,
   input  logic [2:0]         BRANCH,
   input  logic               flagNeg,
   input  logic               flagZero,
   output logic               imemEn,
   output logic [PC_W-1:0]    imemAddr,
   input  logic [INSTR_W-1:0] imemData,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         op_code,
   output logic [3:0]         rd,
   output logic [3:0]         rs1,
   output logic [3:0]         rs2,
   output logic [15:0]        imm,
   output logic               irValid,
   output logic               branchTaken
);

   fetch_state_e    state;
   logic [PC_W-1:0] next_pc;

   branch_resolve #(.PC_W(PC_W)) u_branch_resolve (
      .branch    (BRANCH),
      .flag_neg  (flagNeg),
      .flag_zero (flagZero),
      .pc        (pc),
      .imm       (imm),
      .taken     (branchTaken),
      .next_pc   (next_pc)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         instr   <= NOP_INSTR;
         irValid <= 1'b0;
      end else if (loadPC) begin
         // Any fetch in flight is abandoned: returning ROM data is simply never captured.
         state   <= S_REQ;
         pc      <= next_pc;
         irValid <= 1'b0;
      end else begin
         case (state)
            S_REQ:   state <= S_WAIT;
            S_WAIT: begin
               instr   <= imemData;
               irValid <= 1'b1;
               state   <= S_READY;
            end
            S_READY: state <= S_READY;
            default: state <= S_REQ;
         endcase
      end
   end

   // Request is issued in the REQ cycle itself so the fetch completes two cycles after entering REQ.
   assign imemEn   = (state == S_REQ) && !reset;
   assign imemAddr = pc;

   assign op_code = instr[OP_MSB:OP_LSB];
   assign rd      = instr[RD_MSB:RD_LSB];
   assign rs1     = instr[RS1_MSB:RS1_LSB];
   assign rs2     = instr[RS2_MSB:RS2_LSB];
   assign imm     = instr[IMM_MSB:IMM_LSB];

endmodule
